// File: rtl/taillight_pkg.sv
// Shared types for the sequential tail-light controller: lamp mode encoding
// and the request-priority decoder.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } mode_t;

  // Hazard wins, and a simultaneous left+right request is treated as hazard.
  function automatic mode_t decode_mode(input logic haz, input logic lt, input logic rt);
    if (haz || (lt && rt)) return HAZ;
    else if (lt)           return LEFT;
    else if (rt)           return RIGHT;
    else                   return IDLE;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: pulses tick once every STEP_DIV enabled clocks.
// clear restarts the count; a disabled prescaler sits at zero.
module step_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seq_tail_light.sv
// Parametrised sequential turn-signal / hazard controller with registered lamp
// outputs. Define TAILLIGHT_BRAKE_EN to add the brake-light overlay.
module seq_tail_light
  import taillight_pkg::*;
#(
  parameter int NUM_LAMPS = 3,
  parameter int STEP_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lt,
  input  logic                 rt,
  input  logic                 haz,
  input  logic                 brake,
  output logic [NUM_LAMPS-1:0] li,
  output logic [NUM_LAMPS-1:0] ri,
  output logic                 busy
);

  localparam int PW = $clog2(NUM_LAMPS + 1);

  mode_t                mode, req;
  logic [PW-1:0]        phase, nxt_phase;
  logic                 mode_chg, tick;
  logic [NUM_LAMPS-1:0] mask, nxt_li, nxt_ri;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (mode != IDLE),
    .clear  (mode_chg),
    .tick   (tick)
  );

`ifndef TAILLIGHT_BRAKE_EN
  logic unused_brake;
  assign unused_brake = brake;
`endif

  // Next mode/phase and the lamp pattern they imply; outputs register this so
  // lamps track the mode/phase registers with no input-to-output path.
  always_comb begin
    req       = decode_mode(haz, lt, rt);
    mode_chg  = (req != mode);
    nxt_phase = phase;
    if (mode_chg) begin
      nxt_phase = '0;
    end else if (tick) begin
      case (mode)
        LEFT, RIGHT: nxt_phase = (phase == PW'(NUM_LAMPS)) ? '0 : phase + PW'(1);
        HAZ:         nxt_phase = (phase == '0) ? PW'(1) : '0;
        default:     nxt_phase = '0;
      endcase
    end

    for (int k = 0; k < NUM_LAMPS; k++) begin
      mask[k] = (k < int'(nxt_phase));
    end

    nxt_li = '0;
    nxt_ri = '0;
    case (req)
      LEFT:    nxt_li = mask;
      RIGHT:   nxt_ri = mask;
      HAZ: begin
        nxt_li = (nxt_phase != '0) ? '1 : '0;
        nxt_ri = (nxt_phase != '0) ? '1 : '0;
      end
      default: ;
    endcase

`ifdef TAILLIGHT_BRAKE_EN
    if (brake) begin
      case (req)
        IDLE: begin
          nxt_li = '1;
          nxt_ri = '1;
        end
        LEFT:    nxt_ri = '1;
        RIGHT:   nxt_li = '1;
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode  <= IDLE;
      phase <= '0;
      li    <= '0;
      ri    <= '0;
      busy  <= 1'b0;
    end else begin
      mode  <= req;
      phase <= nxt_phase;
      li    <= nxt_li;
      ri    <= nxt_ri;
      busy  <= (req != IDLE);
    end
  end

endmodule

// File: doc/seq_tail_light.md
Name: seq_tail_light

Overview:
- Parametrised sequential turn-signal/hazard controller for N lamps per side.
- Successor to the fixed 3-lamp tail-light FSM: lamp count and step rate are parameters; it adds an internal step prescaler, a lt+rt conflict rule and an optional brake overlay.
- Sits between the lamp-switch inputs and the lamp drivers; one instance per vehicle.

Parameters:
- NUM_LAMPS, 3, lamps per side (≥1).
- STEP_DIV, 4, clocks per sequence step (≥1). STEP_DIV=1 steps every clock.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lt  input  1  left turn request, level.
- rt  input  1  right turn request, level.
- haz  input  1  hazard request, level.
- brake  input  1  brake pedal, level (used only with TAILLIGHT_BRAKE_EN).
- li  output  NUM_LAMPS  left lamps, bit 0 innermost.
- ri  output  NUM_LAMPS  right lamps, bit 0 innermost.
- busy  output  1  high when mode ≠ IDLE.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; state returns to IDLE, phase=0, prescaler=0; li=0, ri=0, busy=0 immediately on assertion. Mid-sequence reset behaves the same.
- Modes: IDLE, LEFT, RIGHT, HAZ. Requested mode is decoded each cycle with this priority:
  - haz=1 or (lt=1 and rt=1) → HAZ.
  - else lt → LEFT.
  - else rt → RIGHT.
  - else IDLE.
- Mode register updates on the rising edge after the request changes. A mode change clears phase and prescaler on the same edge, so each new mode starts at phase 0 with a full STEP_DIV wait.
- Prescaler: counts 0..STEP_DIV-1 while mode ≠ IDLE. tick=1 when count==STEP_DIV-1, then the count wraps to 0. Held at 0 in IDLE.
- LEFT/RIGHT: phase runs 0..NUM_LAMPS and advances on each tick; it wraps NUM_LAMPS→0.
  - Active side lamps[k]=1 iff k<phase. Phase 0 is all off; phase NUM_LAMPS is all on.
  - Opposite side is 0.
- HAZ: phase toggles 0/1 on each tick. Phase 0 = both sides all off; phase 1 = both sides all on.
- IDLE: li=ri=0.
- Outputs decode from registered mode/phase only. There is no combinational path from inputs to outputs.
- Input-to-first-lamp latency: 1 edge to enter the mode (lamps off), then STEP_DIV edges to phase 1.
- A held request repeats indefinitely. Releasing it returns to IDLE one edge later, even mid-sequence.
- busy=1 exactly when mode ≠ IDLE.

Optional Feature:
- Macro: TAILLIGHT_BRAKE_EN.
- Defined — brake overlay, ORed onto the decoded outputs:
  - IDLE: brake=1 forces li and ri all on.
  - LEFT: brake=1 forces ri all on; li keeps sequencing.
  - RIGHT: brake=1 forces li all on; ri keeps sequencing.
  - HAZ: brake is ignored.
  - brake goes through one register stage, so its effect appears 1 edge after it changes. This register is cleared by rst.
  - brake does not affect mode, phase or busy.
- Undefined: brake is unused and the outputs are as above.

Decomposition:
- Package taillight_pkg:
  - typedef enum logic [1:0] mode_t {IDLE, LEFT, RIGHT, HAZ}.
  - Function decode_mode(haz, lt, rt) returning mode_t.
- One sub-module, step_prescaler:
  - Parameter STEP_DIV.
  - Inputs clk, rst, enable, clear; output tick.
  - Counter width $clog2(STEP_DIV), minimum 1 bit.
- Top holds the mode/phase registers and the output decode.

Test Plan (NUM_LAMPS=3, STEP_DIV=2, all inputs 0 unless noted):
- Reset: assert rst mid-LEFT with li=3'b011 → li=ri=0 and busy=0 immediately, without waiting for a clock edge.
- Left sequence: lt=1 held → edge 1 busy=1 and li=000; li steps 001, 011, 111, 000, repeating every 8 edges after entry; ri=0 throughout.
- Right then release: rt=1 until ri=3'b011, then rt=0 → next edge ri=000 and busy=0.
- Hazard priority: lt=1 and haz=1 → HAZ; li=ri alternate 000/111 every 2 edges. Then lt=1 and rt=1 with haz=0 → still HAZ, with no phase reset because the mode is unchanged.
- Mode switch: during LEFT at li=3'b011, set lt=0 and rt=1 → next edge li=000 and ri=000; ri=001 two edges later.
- TAILLIGHT_BRAKE_EN: brake=1 in IDLE → li=ri=111 one edge later. In LEFT: ri=111 while li keeps sequencing. In HAZ: outputs are unchanged. With the macro undefined, brake has no effect.
